ff_excitation_driver: RTL and testbench
=======================================

FF_EXCITATION_DRIVER -- requirements
Module: ff_excitation_driver

Interface
REQ-001 Parameter CNT_W, default 8: width of the transition counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  run request; 1 = drive and check, 0 = hold.
REQ-005 mode  input  2  target flop type: 00 D, 01 SR, 10 JK, 11 T.
REQ-006 d  input  1  desired next state of the external flop.
REQ-007 q_fb  input  1  Q returned by the external flop under drive.
REQ-008 dq, s, r, j, k, t  output  1 each  registered excitation signals to the external flop.
REQ-009 q_exp, q_exp_bar  output  1 each  model of the external flop's Q, and its complement.
REQ-010 busy  output  1  high in ARM or RUN.
REQ-011 fault  output  1  sticky high after a feedback mismatch.
REQ-012 trans_cnt  output  CNT_W  count of q_exp transitions in RUN, saturating.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ARM, RUN and FAULT.
REQ-014 IDLE SHALL go to ARM when en=1; ARM SHALL go to RUN after exactly one cycle.
REQ-015 RUN SHALL return to IDLE when en=0, and SHALL re-enter ARM when mode differs from its value on the previous edge.
REQ-016 FAULT SHALL be exited only by rst; en and mode are ignored while in FAULT.
REQ-017 q_exp SHALL update each edge by applying the mode's characteristic equation to the current excitation outputs: D q=dq; SR q=s|(~r&q); JK q=(j&~q)|(~k&q); T q=t^q.
REQ-018 In ARM and RUN, each excitation output SHALL register the excitation for q_exp(next)->d, using the next-edge value of q_exp.
REQ-019 Excitation table, per q->d:
- SR: 0->1 s=1 r=0; 1->0 s=0 r=1; otherwise s=r=0.
- JK: 0->1 j=1 k=0; 1->0 j=0 k=1; otherwise j=k=0.
- T: t=q^d.
- D: dq=d.
REQ-020 All excitation outputs not belonging to the selected mode SHALL be 0.
REQ-021 s=r=1 and j=k=1 SHALL never be driven.
REQ-022 In IDLE and FAULT the outputs SHALL hold the flop: s=r=j=k=t=0 and dq=q_exp, so q_exp is unchanged.
REQ-023 Latency: for d sampled at edge N, q_exp SHALL equal d after edge N+1.
REQ-024 Checking SHALL run only in RUN, excluding the first two RUN edges after ARM.
REQ-025 A mismatch SHALL be q_fb != q_exp sampled at a rising edge.
REQ-026 A mismatch SHALL move the FSM to FAULT and set fault=1 on that edge.
REQ-027 trans_cnt SHALL increment on each RUN edge where q_exp changes value.
REQ-028 trans_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 q_exp_bar SHALL always equal ~q_exp.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, with no clock edge needed.
REQ-031 rst=1 SHALL clear q_exp, all excitation outputs, busy, fault and trans_cnt to 0, and drive q_exp_bar=1.
REQ-032 rst asserted mid-RUN or in FAULT SHALL abort without completing any pending excitation.
REQ-033 Operation SHALL resume from IDLE on the first edge after rst deasserts.

Verification
REQ-034 SR mode, flop model correct, en=1, d sequence 0,1,1,0 -> s/r pulses 1/0 then 0/1 on the 0->1 and 1->0 steps, fault stays 0, trans_cnt=2.
REQ-035 JK mode, d toggling every cycle for 10 cycles -> j and k alternate and are never both 1, q_exp tracks d one edge late, trans_cnt=10.
REQ-036 T mode, q_fb forced to 0 while q_exp=1 in RUN -> FAULT on that edge, fault=1, t=0, later changes on en and d ignored.
REQ-037 CNT_W=2, 5 transitions in D mode -> trans_cnt reads 3 and holds.
REQ-038 mode changed SR->T mid-RUN -> one ARM cycle (busy=1), checks suppressed for 2 edges, and no false fault even with q_fb lagging.
REQ-039 rst pulsed between clock edges during RUN with d=1 -> outputs cleared at once, q_exp=0, q_exp_bar=1, fault=0, state IDLE.

Source files
------------

// File: rtl/ff_excitation_driver.sv
// Drives the excitation inputs of an external D/SR/JK/T flip-flop so that it
// follows a requested data stream, and checks the flop's returned Q against a model.
module ff_excitation_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             d,
    input  logic             q_fb,
    output logic             dq,
    output logic             s,
    output logic             r,
    output logic             j,
    output logic             k,
    output logic             t,
    output logic             q_exp,
    output logic             q_exp_bar,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] trans_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] mode_q;
    logic [1:0] mode_prev;
    logic [1:0] run_cnt;
    logic       q_nxt;
    logic       check_en;
    logic       mismatch;
    logic       dq_n;
    logic       s_n;
    logic       r_n;
    logic       j_n;
    logic       k_n;
    logic       t_n;

    // mode_q is the flop type the excitation currently on the outputs was built for.
    always_comb begin
        q_nxt = t ^ q_exp;
        case (mode_q)
            MODE_D:  q_nxt = dq;
            MODE_SR: q_nxt = s | (~r & q_exp);
            MODE_JK: q_nxt = (j & ~q_exp) | (~k & q_exp);
            default: q_nxt = t ^ q_exp;
        endcase
    end

    assign check_en = (state == RUN) && (run_cnt == 2'd2);
    assign mismatch = check_en && (q_fb != q_exp);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = ARM;
            ARM:     state_nxt = RUN;
            RUN: begin
                if (mismatch)
                    state_nxt = FAULT;
                else if (!en)
                    state_nxt = IDLE;
                else if (mode != mode_prev)
                    state_nxt = ARM;
            end
            default: state_nxt = FAULT;
        endcase
    end

    // Excitation is chosen for the state being entered, so IDLE/FAULT hold the flop at once.
    always_comb begin
        dq_n = q_nxt;
        s_n  = 1'b0;
        r_n  = 1'b0;
        j_n  = 1'b0;
        k_n  = 1'b0;
        t_n  = 1'b0;
        if (state_nxt == ARM || state_nxt == RUN) begin
            dq_n = 1'b0;
            case (mode)
                MODE_D:  dq_n = d;
                MODE_SR: begin
                    s_n = ~q_nxt & d;
                    r_n = q_nxt & ~d;
                end
                MODE_JK: begin
                    j_n = ~q_nxt & d;
                    k_n = q_nxt & ~d;
                end
                default: t_n = q_nxt ^ d;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_D;
            mode_prev <= MODE_D;
            run_cnt   <= 2'd0;
            dq        <= 1'b0;
            s         <= 1'b0;
            r         <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            t         <= 1'b0;
            q_exp     <= 1'b0;
            fault     <= 1'b0;
            trans_cnt <= '0;
        end else begin
            state     <= state_nxt;
            mode_q    <= mode;
            mode_prev <= mode;
            dq        <= dq_n;
            s         <= s_n;
            r         <= r_n;
            j         <= j_n;
            k         <= k_n;
            t         <= t_n;
            q_exp     <= q_nxt;
            // The first two RUN edges after ARM are not checked; the flop may still be settling.
            if (state == ARM)
                run_cnt <= 2'd0;
            else if (state == RUN && run_cnt != 2'd2)
                run_cnt <= run_cnt + 2'd1;
            if (mismatch)
                fault <= 1'b1;
            if (state == RUN && q_nxt != q_exp && trans_cnt != {CNT_W{1'b1}})
                trans_cnt <= trans_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign busy      = (state == ARM) || (state == RUN);
    assign q_exp_bar = ~q_exp;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Self-checking bench for ff_excitation_driver: a behavioural external flop feeds
// q_fb, and a scoreboard queue holds the q_exp value each driven d must produce.
module tb_ff_excitation_driver;

    localparam logic [1:0] M_D  = 2'b00;
    localparam logic [1:0] M_SR = 2'b01;
    localparam logic [1:0] M_JK = 2'b10;
    localparam logic [1:0] M_T  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] mode = M_D;
    logic       d   = 1'b0;
    logic       q_fb;

    logic       dq, s, r, j, k, t, q_exp, q_exp_bar, busy, fault;
    logic [7:0] trans_cnt;
    logic       dq_2, s_2, r_2, j_2, k_2, t_2, q_exp_2, q_exp_bar_2, busy_2, fault_2;
    logic [1:0] trans_cnt_2;

    logic       ext_q, lag_q;
    logic [1:0] ext_mode;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic       lag_en = 1'b0;

    typedef struct {
        int   due;
        logic val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    ff_excitation_driver #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .q_fb(q_fb),
        .dq(dq), .s(s), .r(r), .j(j), .k(k), .t(t),
        .q_exp(q_exp), .q_exp_bar(q_exp_bar), .busy(busy), .fault(fault),
        .trans_cnt(trans_cnt)
    );

    ff_excitation_driver #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .q_fb(q_fb),
        .dq(dq_2), .s(s_2), .r(r_2), .j(j_2), .k(k_2), .t(t_2),
        .q_exp(q_exp_2), .q_exp_bar(q_exp_bar_2), .busy(busy_2), .fault(fault_2),
        .trans_cnt(trans_cnt_2)
    );

    always #5 clk = ~clk;

    // Behavioural model of the physical flop under drive; lag_q gives a one-cycle-late Q.
    function automatic logic flop_next(input logic [1:0] m, input logic q,
                                       input logic dv, sv, rv, jv, kv, tv);
        case (m)
            M_D:     return dv;
            M_SR:    return sv | (~rv & q);
            M_JK:    return (jv & ~q) | (~kv & q);
            default: return tv ^ q;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q    <= 1'b0;
            lag_q    <= 1'b0;
            ext_mode <= M_D;
        end else begin
            ext_mode <= mode;
            ext_q    <= flop_next(ext_mode, ext_q, dq, s, r, j, k, t);
            lag_q    <= ext_q;
        end
    end

    assign q_fb = force_en ? force_val : (lag_en ? lag_q : ext_q);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checkOutput("sb_q_exp", {31'd0, q_exp}, {31'd0, e.val});
            checkOutput("sb_q_exp_bar", {31'd0, q_exp_bar}, {31'd0, ~e.val});
        end
    endtask

    // d driven now is sampled at the next edge and must appear on q_exp one edge later.
    task automatic applyStimulus(input logic e_v, input logic [1:0] m_v, input logic d_v,
                                 input bit track);
        exp_t e;
        en   = e_v;
        mode = m_v;
        d    = d_v;
        if (track) begin
            e.due = cyc + 2;
            e.val = d_v;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic end_test();
        applyStimulus(1'b0, mode, d, 1'b0);
        applyStimulus(1'b0, mode, d, 1'b0);
        do_reset();
    endtask

    initial begin
        #2;
        checkOutput("rst_q_exp", {31'd0, q_exp}, 32'd0);
        checkOutput("rst_q_exp_bar", {31'd0, q_exp_bar}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_exc", {26'd0, dq, s, r, j, k, t}, 32'd0);
        checkOutput("rst_trans_cnt", {24'd0, trans_cnt}, 32'd0);
        do_reset();

        // SR: d = 0,1,1,0 gives a set pulse then a reset pulse
        applyStimulus(1'b1, M_SR, 1'b0, 1'b1);
        checkOutput("sr_busy_arm", {31'd0, busy}, 32'd1);
        applyStimulus(1'b1, M_SR, 1'b1, 1'b1);
        checkOutput("sr_set_pulse", {30'd0, s, r}, 32'b10);
        applyStimulus(1'b1, M_SR, 1'b1, 1'b1);
        checkOutput("sr_hold_one", {30'd0, s, r}, 32'b00);
        applyStimulus(1'b1, M_SR, 1'b0, 1'b1);
        checkOutput("sr_reset_pulse", {30'd0, s, r}, 32'b01);
        checkOutput("sr_others_zero", {28'd0, dq, j, k, t}, 32'd0);
        applyStimulus(1'b1, M_SR, 1'b0, 1'b1);
        applyStimulus(1'b1, M_SR, 1'b0, 1'b1);
        checkOutput("sr_fault", {31'd0, fault}, 32'd0);
        checkOutput("sr_trans_cnt", {24'd0, trans_cnt}, 32'd2);
        end_test();

        // JK: d toggles each cycle for 10 cycles
        applyStimulus(1'b1, M_JK, 1'b0, 1'b1);
        applyStimulus(1'b1, M_JK, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            logic dv;
            dv = (i % 2 == 0);
            applyStimulus(1'b1, M_JK, dv, 1'b1);
            checkOutput("jk_jk", {30'd0, j, k}, {30'd0, dv, ~dv});
        end
        applyStimulus(1'b1, M_JK, 1'b0, 1'b1);
        applyStimulus(1'b1, M_JK, 1'b0, 1'b1);
        checkOutput("jk_trans_cnt", {24'd0, trans_cnt}, 32'd10);
        checkOutput("jk_fault", {31'd0, fault}, 32'd0);
        end_test();

        // T: force q_fb low while q_exp is high in RUN
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, M_T, 1'b1, 1'b1);
        checkOutput("t_fault_before", {31'd0, fault}, 32'd0);
        force_en  = 1'b1;
        force_val = 1'b0;
        applyStimulus(1'b1, M_T, 1'b1, 1'b0);
        checkOutput("t_fault_set", {31'd0, fault}, 32'd1);
        checkOutput("t_fault_busy", {31'd0, busy}, 32'd0);
        checkOutput("t_fault_t", {31'd0, t}, 32'd0);
        applyStimulus(1'b0, M_T, 1'b0, 1'b0);
        applyStimulus(1'b1, M_D, 1'b0, 1'b0);
        applyStimulus(1'b1, M_T, 1'b0, 1'b0);
        checkOutput("t_fault_sticky", {31'd0, fault}, 32'd1);
        checkOutput("t_fault_idle", {31'd0, busy}, 32'd0);
        checkOutput("t_fault_q_hold", {31'd0, q_exp}, 32'd1);
        checkOutput("t_fault_exc", {26'd0, dq, s, r, j, k, t}, 32'b100000);
        force_en = 1'b0;
        do_reset();
        checkOutput("t_fault_cleared", {31'd0, fault}, 32'd0);

        // D: 5 transitions saturate the 2-bit counter, then 2 more
        applyStimulus(1'b1, M_D, 1'b0, 1'b1);
        applyStimulus(1'b1, M_D, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, M_D, (i % 2 == 0), 1'b1);
        applyStimulus(1'b1, M_D, 1'b1, 1'b1);
        applyStimulus(1'b1, M_D, 1'b1, 1'b1);
        checkOutput("d_cnt_wide", {24'd0, trans_cnt}, 32'd5);
        checkOutput("d_cnt_sat", {30'd0, trans_cnt_2}, 32'd3);
        applyStimulus(1'b1, M_D, 1'b0, 1'b1);
        applyStimulus(1'b1, M_D, 1'b1, 1'b1);
        applyStimulus(1'b1, M_D, 1'b1, 1'b1);
        checkOutput("d_cnt_wide2", {24'd0, trans_cnt}, 32'd7);
        checkOutput("d_cnt_sat_hold", {30'd0, trans_cnt_2}, 32'd3);
        end_test();

        // SR -> T mid-RUN with a lagging q_fb
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, M_SR, 1'b1, 1'b1);
        lag_en = 1'b1;
        applyStimulus(1'b1, M_T, 1'b0, 1'b1);
        checkOutput("mc_busy_arm", {31'd0, busy}, 32'd1);
        checkOutput("mc_t_exc", {26'd0, dq, s, r, j, k, t}, 32'b000001);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, M_T, 1'b0, 1'b1);
            checkOutput("mc_no_fault", {31'd0, fault}, 32'd0);
        end
        checkOutput("mc_busy_run", {31'd0, busy}, 32'd1);
        lag_en = 1'b0;
        end_test();

        // Asynchronous reset between edges during RUN with d=1
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, M_D, 1'b1, 1'b1);
        checkOutput("ar_pre_q", {31'd0, q_exp}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        sb.delete();
        checkOutput("ar_q_exp", {31'd0, q_exp}, 32'd0);
        checkOutput("ar_q_exp_bar", {31'd0, q_exp_bar}, 32'd1);
        checkOutput("ar_fault", {31'd0, fault}, 32'd0);
        checkOutput("ar_busy", {31'd0, busy}, 32'd0);
        checkOutput("ar_exc", {26'd0, dq, s, r, j, k, t}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, M_D, 1'b0, 1'b0);
        checkOutput("ar_resume_busy", {31'd0, busy}, 32'd1);
        end_test();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
